// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the pipeline stage register with skid buffer.
//   NOP_IR_DEF : instruction word shown when the stage holds no valid entry
//   state_t    : occupancy state of the stage (2'd3 is unused and decodes as EMPTY)
package pipe_stage_skid_pkg;

    localparam logic [15:0] NOP_IR_DEF = 16'hF000;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_stage_skid_entry.sv
// One storage entry of the stage: valid bit + instruction word + payload.
// Ports:
//   clk      in   clock
//   i_clr    in   asynchronous active-high reset
//   i_load   in   capture i_valid/i_ir/i_data
//   i_clear  in   squash to empty bubble (NOP_IR, zero payload); wins over i_load
//   i_valid  in   valid bit to capture with the entry
//   i_ir     in   instruction word to capture
//   i_data   in   payload to capture
//   o_valid  out  entry valid
//   o_ir     out  stored instruction word (NOP_IR when empty)
//   o_data   out  stored payload (zero when empty)
module pipe_stage_skid_entry
    import pipe_stage_skid_pkg::*;
#(
    parameter int              IR_W   = 16,
    parameter int              DATA_W = 57,
    parameter logic [IR_W-1:0] NOP_IR = IR_W'(NOP_IR_DEF)
) (
    input  logic              clk,
    input  logic              i_clr,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic              i_valid,
    input  logic [IR_W-1:0]   i_ir,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [IR_W-1:0]   o_ir,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [IR_W-1:0]   r_ir;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge clk or posedge i_clr) begin
        if (i_clr) begin
            r_valid <= 1'b0;
            r_ir    <= NOP_IR;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_ir    <= NOP_IR;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= i_valid;
            r_ir    <= i_ir;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_ir    = r_ir;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake and a 2-entry skid
// buffer. The main entry drives the outputs directly; the skid entry absorbs
// one extra word when downstream stalls. Ready is registered, so there is no
// combinational path from any input to any output.
// Ports:
//   clk          in   clock
//   i_clr        in   asynchronous active-high reset
//   i_flush      in   synchronous squash to an empty bubble, over normal flow
//   i_valid      in   upstream entry valid
//   o_ready      out  stage can accept this cycle (registered)
//   i_ir         in   upstream instruction word
//   i_data       in   upstream payload
//   o_valid      out  downstream entry valid
//   i_ready      in   downstream accepts this cycle
//   o_ir         out  instruction word to next stage (NOP_IR when not valid)
//   o_data       out  payload to next stage (zero when not valid)
//   o_stall_cnt  out  saturating count of cycles with o_valid & !i_ready
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int              IR_W   = 16,
    parameter int              DATA_W = 57,
    parameter logic [IR_W-1:0] NOP_IR = IR_W'(NOP_IR_DEF),
    parameter int              CNT_W  = 16
) (
    input  logic              clk,
    input  logic              i_clr,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [IR_W-1:0]   i_ir,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [IR_W-1:0]   o_ir,
    output logic [DATA_W-1:0] o_data,
    output logic [CNT_W-1:0]  o_stall_cnt
);

    state_t             r_state;
    state_t             w_state_next;
    logic               r_in_ready;
    logic [CNT_W-1:0]   r_stall_cnt;

    logic               w_acc;
    logic               w_pop;
    logic               w_main_load;
    logic               w_main_clear;
    logic               w_main_from_skid;
    logic               w_skid_load;
    logic               w_skid_clear;

    logic               w_main_valid;
    logic               w_skid_valid;
    logic [IR_W-1:0]    w_skid_ir;
    logic [DATA_W-1:0]  w_skid_data;
    logic               w_main_in_valid;
    logic [IR_W-1:0]    w_main_in_ir;
    logic [DATA_W-1:0]  w_main_in_data;

    assign w_acc = i_valid & r_in_ready;
    assign w_pop = w_main_valid & i_ready;

    always_ff @(posedge clk or posedge i_clr) begin
        if (i_clr) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= (w_state_next != ST_TWO);
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_main_load      = 1'b0;
        w_main_clear     = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        w_skid_clear     = 1'b0;
        if (i_flush) begin
            // Any offered entry is discarded along with both stored entries.
            w_state_next = ST_EMPTY;
            w_main_clear = 1'b1;
            w_skid_clear = 1'b1;
        end else begin
            case (r_state)
                ST_ONE: begin
                    if (w_acc && w_pop) begin
                        w_main_load = 1'b1;
                    end else if (w_acc) begin
                        w_state_next = ST_TWO;
                        w_skid_load  = 1'b1;
                    end else if (w_pop) begin
                        w_state_next = ST_EMPTY;
                        w_main_clear = 1'b1;
                    end
                end
                ST_TWO: begin
                    if (w_pop) begin
                        w_state_next     = ST_ONE;
                        w_main_load      = 1'b1;
                        w_main_from_skid = 1'b1;
                        w_skid_clear     = 1'b1;
                    end
                end
                default: begin
                    // EMPTY, and the unused encoding decodes the same way.
                    if (w_acc) begin
                        w_state_next = ST_ONE;
                        w_main_load  = 1'b1;
                    end else begin
                        w_state_next = ST_EMPTY;
                    end
                end
            endcase
        end
    end

    assign w_main_in_valid = w_main_from_skid ? w_skid_valid : 1'b1;
    assign w_main_in_ir    = w_main_from_skid ? w_skid_ir    : i_ir;
    assign w_main_in_data  = w_main_from_skid ? w_skid_data  : i_data;

    pipe_stage_skid_entry #(
        .IR_W   (IR_W),
        .DATA_W (DATA_W),
        .NOP_IR (NOP_IR)
    ) u_main (
        .clk     (clk),
        .i_clr   (i_clr),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_valid (w_main_in_valid),
        .i_ir    (w_main_in_ir),
        .i_data  (w_main_in_data),
        .o_valid (w_main_valid),
        .o_ir    (o_ir),
        .o_data  (o_data)
    );

    pipe_stage_skid_entry #(
        .IR_W   (IR_W),
        .DATA_W (DATA_W),
        .NOP_IR (NOP_IR)
    ) u_skid (
        .clk     (clk),
        .i_clr   (i_clr),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_valid (1'b1),
        .i_ir    (i_ir),
        .i_data  (i_data),
        .o_valid (w_skid_valid),
        .o_ir    (w_skid_ir),
        .o_data  (w_skid_data)
    );

    // Counts stalled cycles including flush cycles; sticks at all-ones.
    always_ff @(posedge clk or posedge i_clr) begin
        if (i_clr) begin
            r_stall_cnt <= '0;
        end else if (w_main_valid && !i_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign o_ready     = r_in_ready;
    assign o_valid     = w_main_valid;
    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        i_clr;
    logic        i_flush;
    logic        i_valid;
    logic        o_ready;
    logic [15:0] i_ir;
    logic [56:0] i_data;
    logic        o_valid;
    logic        i_ready;
    logic [15:0] o_ir;
    logic [56:0] o_data;
    logic [3:0]  o_stall_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(
        .IR_W   (16),
        .DATA_W (57),
        .NOP_IR (16'hF000),
        .CNT_W  (4)
    ) dut (
        .clk         (clk),
        .i_clr       (i_clr),
        .i_flush     (i_flush),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_ir        (i_ir),
        .i_data      (i_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_ir        (o_ir),
        .o_data      (o_data),
        .o_stall_cnt (o_stall_cnt)
    );

    function automatic logic [56:0] mkdata(input logic [15:0] ir);
        return {ir, ~ir, ir ^ 16'h5a5a, ir[8:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp, input bit quiet = 1'b0);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        if (!quiet) $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_clr = 1'b1;
        #2;
        i_clr = 1'b0;
        #1;
    endtask

    logic [15:0] q[$];
    int          pops;

    initial begin
        i_clr = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        i_ir = 16'h0; i_data = '0;
        step();
        i_clr = 1'b0;
        step();

        // 1: async reset mid-traffic
        i_valid = 1'b1; i_ir = 16'h0A01; i_data = mkdata(16'h0A01); step();
        i_ir = 16'h0A02; i_data = mkdata(16'h0A02); step();
        i_valid = 1'b0;
        chk("pre_rst_ready", 64'(o_ready), 64'd0);
        chk("pre_rst_cnt", 64'(o_stall_cnt), 64'd1);
        #3;
        i_clr = 1'b1;
        #1;
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_ir", 64'(o_ir), 64'hF000);
        chk("rst_data", 64'(o_data), 64'd0);
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_cnt", 64'(o_stall_cnt), 64'd0);
        i_clr = 1'b0;
        step();

        // 2: streaming, out ready always high
        i_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            i_valid = 1'b1;
            i_ir    = 16'h1001 + 16'(k);
            i_data  = mkdata(16'h1001 + 16'(k));
            chk("stream_ready", 64'(o_ready), 64'd1);
            step();
            chk("stream_valid", 64'(o_valid), 64'd1);
            chk("stream_ir", 64'(o_ir), 64'(16'h1001 + 16'(k)));
            chk("stream_data", 64'(o_data), 64'(mkdata(16'h1001 + 16'(k))));
        end
        i_valid = 1'b0;
        step();
        chk("stream_end_valid", 64'(o_valid), 64'd0);
        chk("stream_end_ir", 64'(o_ir), 64'hF000);
        chk("stream_end_data", 64'(o_data), 64'd0);

        // 3: skid absorb and drain
        do_reset();
        i_ready = 1'b0;
        i_valid = 1'b1; i_ir = 16'h2001; i_data = mkdata(16'h2001); step();
        chk("skid_one_ir", 64'(o_ir), 64'h2001);
        i_ir = 16'h2002; i_data = mkdata(16'h2002); step();
        i_valid = 1'b0;
        chk("skid_ready_low", 64'(o_ready), 64'd0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("skid_hold_ir", 64'(o_ir), 64'h2001);
            chk("skid_hold_data", 64'(o_data), 64'(mkdata(16'h2001)));
        end
        chk("skid_cnt", 64'(o_stall_cnt), 64'd6);
        i_ready = 1'b1;
        chk("skid_out1", 64'(o_ir), 64'h2001);
        step();
        chk("skid_out2", 64'(o_ir), 64'h2002);
        chk("skid_out2_data", 64'(o_data), 64'(mkdata(16'h2002)));
        chk("skid_ready_back", 64'(o_ready), 64'd1);
        step();
        chk("skid_drained", 64'(o_valid), 64'd0);
        chk("skid_cnt_final", 64'(o_stall_cnt), 64'd6);

        // 4: flush in TWO with an entry offered
        do_reset();
        i_ready = 1'b0;
        i_valid = 1'b1; i_ir = 16'h3001; i_data = mkdata(16'h3001); step();
        i_ir = 16'h3002; i_data = mkdata(16'h3002); step();
        i_ir = 16'h3003; i_data = mkdata(16'h3003); i_flush = 1'b1; step();
        i_flush = 1'b0; i_valid = 1'b0;
        chk("flush_valid", 64'(o_valid), 64'd0);
        chk("flush_ir", 64'(o_ir), 64'hF000);
        chk("flush_data", 64'(o_data), 64'd0);
        chk("flush_ready", 64'(o_ready), 64'd1);
        chk("flush_cnt", 64'(o_stall_cnt), 64'd2);
        i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("flush_no_ghost", 64'(o_valid), 64'd0);
        end
        // flush beats an accept in EMPTY
        i_valid = 1'b1; i_ir = 16'h3005; i_data = mkdata(16'h3005); i_flush = 1'b1; step();
        i_valid = 1'b0; i_flush = 1'b0;
        chk("flush_acc_drop", 64'(o_valid), 64'd0);
        chk("flush_acc_ir", 64'(o_ir), 64'hF000);

        // 5: counter saturation
        do_reset();
        i_ready = 1'b0;
        i_valid = 1'b1; i_ir = 16'h5001; i_data = mkdata(16'h5001); step();
        i_valid = 1'b0;
        for (int k = 0; k < 10; k++) step();
        chk("sat_mid", 64'(o_stall_cnt), 64'd10);
        for (int k = 0; k < 10; k++) step();
        chk("sat_top", 64'(o_stall_cnt), 64'hF);

        // 6: random valid/ready against a queue model
        do_reset();
        pops = 0;
        for (int c = 0; c < 2000; c++) begin
            logic        v;
            logic        r;
            logic [15:0] ir;
            logic        acc;
            logic        pop;
            v  = 1'($urandom_range(0, 1));
            r  = 1'($urandom_range(0, 1));
            ir = 16'($urandom);
            i_valid = v; i_ready = r; i_ir = ir; i_data = mkdata(ir);
            chk("rnd_ready", 64'(o_ready), 64'(q.size() < 2), 1'b1);
            chk("rnd_valid", 64'(o_valid), 64'(q.size() > 0), 1'b1);
            if (q.size() > 0) begin
                chk("rnd_ir", 64'(o_ir), 64'(q[0]), 1'b1);
                chk("rnd_data", 64'(o_data), 64'(mkdata(q[0])), 1'b1);
            end else begin
                chk("rnd_nop", 64'(o_ir), 64'hF000, 1'b1);
            end
            acc = v && (q.size() < 2);
            pop = r && (q.size() > 0);
            step();
            if (pop) begin
                void'(q.pop_front());
                pops++;
            end
            if (acc) q.push_back(ir);
        end
        i_valid = 1'b0; i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (q.size() > 0) chk("rnd_drain_ir", 64'(o_ir), 64'(q[0]));
            if (q.size() > 0) void'(q.pop_front());
            step();
        end
        chk("rnd_drain_valid", 64'(o_valid), 64'd0);
        $display("random phase: pops=%0d", pops);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
